// File: rtl/ysyx_ifu.sv
// Instruction fetch unit: one outstanding imem request, response capture,
// valid/ready delivery of {inst, pc} to decode, and redirect handling.
module ysyx_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        redirect_misalign,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic            drop;

  // Both handshake flags are pure decodes of the state register.
  assign imem_req_valid = (state == REQ);
  assign inst_valid     = (state == OUT);
  assign imem_req_addr  = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      fetch_pc          <= RESET_PC;
      drop              <= 1'b0;
      inst              <= '0;
      pc                <= RESET_PC;
      fetch_cnt         <= '0;
      redirect_misalign <= 1'b0;
    end else begin
      redirect_misalign <= 1'b0;
      if (redirect_valid) begin
        // Redirect wins over every other event; a request already accepted
        // for the old address leaves a response that must be dropped.
        fetch_pc          <= {redirect_pc[XLEN-1:2], 2'b00};
        redirect_misalign <= |redirect_pc[1:0];
        case (state)
          IDLE: state <= REQ;
          REQ: begin
            if (imem_req_ready) begin
              state <= WAIT;
              drop  <= 1'b1;
            end
          end
          WAIT: begin
            if (imem_resp_valid) begin
              state <= REQ;
              drop  <= 1'b0;
            end else begin
              drop  <= 1'b1;
            end
          end
          OUT: begin
            state <= REQ;
            if (inst_ready) fetch_cnt <= fetch_cnt + XLEN'(1);
          end
          default: state <= IDLE;
        endcase
      end else begin
        case (state)
          IDLE: state <= REQ;
          REQ: begin
            if (imem_req_ready) state <= WAIT;
          end
          WAIT: begin
            if (imem_resp_valid) begin
              if (drop) begin
                drop  <= 1'b0;
                state <= REQ;
              end else begin
                inst  <= imem_resp_data;
                pc    <= fetch_pc;
                state <= OUT;
              end
            end
          end
          OUT: begin
            if (inst_ready) begin
              fetch_pc  <= fetch_pc + PC_STEP;
              fetch_cnt <= fetch_cnt + XLEN'(1);
              state     <= REQ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ysyx_ifu.md
# ysyx_ifu

Instruction fetch unit for the single-issue RV32 core. Holds the fetch PC, issues one instruction-memory request at a time over a valid/ready request channel, and captures the response. It presents `{inst, pc}` to the decode stage over a valid/ready handshake, and accepts PC redirects from the jump/branch path that uses the decoder's `do_jump`. Stale responses are discarded after a redirect.

## Interface
- `RESET_PC`, default 32'h8000_0000, first fetch address after reset (word-aligned).
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_req_addr`  out  32  fetch address (always word-aligned).
- `imem_resp_valid`  in  1  response data valid (one pulse per accepted request).
- `imem_resp_data`  in  32  instruction word.
- `redirect_valid`  in  1  jump taken; replace fetch PC.
- `redirect_pc`  in  32  jump target.
- `redirect_misalign`  out  1  one-cycle pulse: the last accepted redirect target had bits[1:0] != 0.
- `inst_valid`  out  1  `inst`/`pc` valid toward decode.
- `inst_ready`  in  1  decode consumes this cycle.
- `inst`  out  32  fetched instruction.
- `pc`  out  32  address of `inst`.
- `fetch_cnt`  out  32  count of instructions delivered to decode; wraps modulo 2^32.

## Operation
- Internal registers:
  - `fetch_pc` (32)
  - `drop` (1): an outstanding response must be discarded
  - state ∈ {IDLE, REQ, WAIT, OUT}
- `imem_req_valid` = (state == REQ).
- `imem_req_addr` = `fetch_pc`.
- `inst_valid` = (state == OUT).
- State transitions:
  - IDLE → REQ unconditionally. IDLE is entered only from reset.
  - REQ: on `imem_req_valid && imem_req_ready` → WAIT.
  - WAIT: on `imem_resp_valid` with `drop == 0`, latch `inst <= imem_resp_data` and `pc <= fetch_pc`, then → OUT. With `drop == 1`, discard the data, clear `drop`, and → REQ.
  - OUT: on `inst_ready` → REQ, with `fetch_pc <= fetch_pc + 4` (32-bit wrap) and `fetch_cnt` incremented.
- Redirect (`redirect_valid`) has priority over every other event in the same cycle:
  - Always: `fetch_pc <= {redirect_pc[31:2], 2'b00}`; `redirect_misalign <= |redirect_pc[1:0]`.
  - REQ, no handshake this cycle: stay in REQ; the next request uses the new address.
  - REQ with handshake in the same cycle (old address accepted): → WAIT with `drop <= 1`.
  - WAIT without a response: stay in WAIT with `drop <= 1`.
  - WAIT with a response in the same cycle: discard the response, → REQ, `drop <= 0`.
  - OUT: discard the held instruction, → REQ. If `inst_ready` is also high, the instruction counts as consumed (`fetch_cnt` increments), but `fetch_pc` takes the target, not +4.
  - IDLE: the redirect is applied to `fetch_pc`; → REQ.
- `imem_resp_valid` in any state other than WAIT is ignored.
- `inst` and `pc` are stable while `inst_valid == 1` and no redirect occurs.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - state = IDLE, `fetch_pc` = `RESET_PC`, `drop` = 0
  - `inst` = 0, `pc` = `RESET_PC`, `fetch_cnt` = 0, `redirect_misalign` = 0
  - Therefore `imem_req_valid` = 0 and `inst_valid` = 0 during reset.
- First `imem_req_valid` is in the first full cycle after reset deassertion (IDLE lasts exactly 1 cycle).
- Request accepted at cycle t, response at t+k (k ≥ 1) → `inst_valid` high at t+k+1.
- Minimum throughput with k = 1 and `inst_ready` held high: one instruction every 3 cycles (REQ, WAIT, OUT).
- Only one outstanding request at any time; `imem_req_valid` is never high in WAIT or OUT.
- `redirect_misalign` is high for exactly one cycle after the redirect edge, then returns to 0.
- Reset asserted mid-WAIT: the outstanding transaction is abandoned. Any response arriving after reset while in IDLE or REQ is ignored.

## Test plan
- Reset and linear fetch:
  - Stimulus: release reset; `imem_req_ready` = 1, k = 1, `inst_ready` = 1.
  - Required: request addresses 0x80000000, 0x80000004, 0x80000008 on every third cycle; `inst`/`pc` match; `fetch_cnt` = 3 after the third delivery.
- Backpressure:
  - Stimulus: hold `inst_ready` = 0 for 5 cycles while in OUT.
  - Required: `inst_valid` stays 1; `inst`/`pc` unchanged; no new request; on release, next address is +4.
- Redirect in WAIT:
  - Stimulus: request 0x80000004 accepted; assert `redirect_valid` with target 0x80000100 before the response; response 0xDEADBEEF arrives.
  - Required: 0xDEADBEEF never appears on `inst`; next request address is 0x80000100.
- Redirect in OUT with simultaneous `inst_ready`:
  - Required: `fetch_cnt` increments by 1; next request is to the target, not pc+4.
- Misaligned target:
  - Stimulus: `redirect_pc` = 0x80000102.
  - Required: next request to 0x80000100; `redirect_misalign` pulses high for 1 cycle.
- Mid-fetch reset:
  - Stimulus: drop `rst_n` while in WAIT; deliver a response during reset and in the first cycle after release.
  - Required: all outputs at reset values; response ignored; fetch restarts at 0x80000000.
